// File: rtl/waveform_addr_gen.sv
// Phase-accumulator address generator for a combinational waveform ROM.
// Prescaled sample ticks, continuous or N-period burst, valid/ready config port.
module waveform_addr_gen #(
    parameter int ACC_W  = 24,
    parameter int ADDR_W = 8,
    parameter int DIV_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_sel,
    input  logic [ACC_W-1:0]  cfg_data,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    output logic [ADDR_W-1:0] address,
    output logic              addr_valid,
    output logic              wrap,
    output logic              busy,
    output logic              done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   phase_reg, phase_next;
    logic [DIV_W-1:0]   presc_reg, presc_next;
    logic [CNT_W-1:0]   bcnt_reg, bcnt_next;
    logic               mode_reg, mode_next;
    logic [ACC_W-1:0]   ftw_reg, ftw_next;
    logic [ACC_W-1:0]   offset_reg, offset_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic [CNT_W-1:0]   burst_reg, burst_next;
    logic [ADDR_W-1:0]  address_reg, address_next;
    logic               addr_valid_reg, addr_valid_next;
    logic               wrap_reg, wrap_next;
    logic               done_reg, done_next;

    logic               cfg_we;
    logic               tick;
    logic [ACC_W:0]     phase_sum;
    logic [ACC_W-1:0]   addr_sum;
    logic [CNT_W-1:0]   bcnt_inc;
    logic [ADDR_W-1:0]  start_addr;
    logic [ADDR_W-1:0]  tick_addr;

    assign cfg_ready  = (state_reg == IDLE) || !cfg_sel[1];
    assign cfg_we     = cfg_valid && cfg_ready;
    assign tick       = (presc_reg == div_reg - DIV_W'(1));
    assign phase_sum  = {1'b0, phase_reg} + {1'b0, ftw_reg};
    assign addr_sum   = phase_sum[ACC_W-1:0] + offset_reg;
    assign bcnt_inc   = bcnt_reg + CNT_W'(1);
    // Shift rather than slice so every bit of the sums is consumed
    assign start_addr = ADDR_W'(offset_reg >> (ACC_W - ADDR_W));
    assign tick_addr  = ADDR_W'(addr_sum >> (ACC_W - ADDR_W));

    always_comb begin
        ftw_next    = ftw_reg;
        offset_next = offset_reg;
        div_next    = div_reg;
        burst_next  = burst_reg;
        if (cfg_we) begin
            case (cfg_sel)
                2'd0: ftw_next    = cfg_data;
                2'd1: offset_next = cfg_data;
                2'd2: div_next    = (cfg_data[DIV_W-1:0] == '0) ? DIV_W'(1) : cfg_data[DIV_W-1:0];
                default: burst_next = cfg_data[CNT_W-1:0];
            endcase
        end
    end

    always_comb begin
        state_next      = state_reg;
        phase_next      = phase_reg;
        presc_next      = presc_reg;
        bcnt_next       = bcnt_reg;
        mode_next       = mode_reg;
        address_next    = address_reg;
        addr_valid_next = 1'b0;
        wrap_next       = 1'b0;
        done_next       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !stop) begin
                    if (mode && burst_reg == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next      = RUN;
                        phase_next      = '0;
                        presc_next      = '0;
                        bcnt_next       = '0;
                        mode_next       = mode;
                        address_next    = start_addr;
                        addr_valid_next = 1'b1;
                    end
                end
            end
            default: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (tick) begin
                    presc_next      = '0;
                    phase_next      = phase_sum[ACC_W-1:0];
                    address_next    = tick_addr;
                    addr_valid_next = 1'b1;
                    wrap_next       = phase_sum[ACC_W];
                    if (mode_reg && phase_sum[ACC_W]) begin
                        bcnt_next = bcnt_inc;
                        if (bcnt_inc == burst_reg) begin
                            done_next  = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end else begin
                    presc_next = presc_reg + DIV_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            phase_reg      <= '0;
            presc_reg      <= '0;
            bcnt_reg       <= '0;
            mode_reg       <= 1'b0;
            ftw_reg        <= '0;
            offset_reg     <= '0;
            div_reg        <= DIV_W'(1);
            burst_reg      <= CNT_W'(1);
            address_reg    <= '0;
            addr_valid_reg <= 1'b0;
            wrap_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            presc_reg      <= presc_next;
            bcnt_reg       <= bcnt_next;
            mode_reg       <= mode_next;
            ftw_reg        <= ftw_next;
            offset_reg     <= offset_next;
            div_reg        <= div_next;
            burst_reg      <= burst_next;
            address_reg    <= address_next;
            addr_valid_reg <= addr_valid_next;
            wrap_reg       <= wrap_next;
            done_reg       <= done_next;
        end
    end

    assign address    = address_reg;
    assign addr_valid = addr_valid_reg;
    assign wrap       = wrap_reg;
    assign done       = done_reg;
    assign busy       = (state_reg == RUN);

endmodule

// File: tb/tb_waveform_addr_gen.sv
// Directed self-checking bench for waveform_addr_gen: ramps, prescaling,
// offset, bursts, stop/reconfiguration, reset and start corner cases.
module tb_waveform_addr_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_sel;
    logic [23:0] cfg_data;
    logic        start;
    logic        stop;
    logic        mode;
    logic [7:0]  address;
    logic        addr_valid;
    logic        wrap;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    waveform_addr_gen dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_sel    (cfg_sel),
        .cfg_data   (cfg_data),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .address    (address),
        .addr_valid (addr_valid),
        .wrap       (wrap),
        .busy       (busy),
        .done       (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [23:0] data);
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_data  = data;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start(input logic m);
        start = 1'b1;
        mode  = m;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_valid = 1'b0; cfg_sel = 2'd3; cfg_data = '0;
        start = 1'b0; stop = 1'b0; mode = 1'b0;
        #2;
        n_cmp++;
        if ({address, addr_valid, wrap, busy, done} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got addr=%h av=%b wrap=%b busy=%b done=%b, want all 0",
                     address, addr_valid, wrap, busy, done);
        end
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready);
        end
        step(); step();
        reset = 1'b0;
        step();
        $display("test_reset complete");
    endtask

    task automatic test_ramp();
        cfg_write(2'd0, 24'h010000);
        do_start(1'b0);
        n_cmp++;
        if (addr_valid !== 1'b1 || address !== 8'h00 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL ramp_first: got av=%b addr=%h busy=%b want 1/00/1", addr_valid, address, busy);
        end
        for (int i = 1; i <= 256; i++) begin
            step();
            n_cmp++;
            if (addr_valid !== 1'b1 || address !== 8'(i) || wrap !== logic'(i == 256)) begin
                n_err++;
                $display("FAIL ramp_tick%0d: got av=%b addr=%h wrap=%b want 1/%h/%b",
                         i, addr_valid, address, wrap, 8'(i), (i == 256));
            end
        end
        do_stop();
        $display("test_ramp complete");
    endtask

    task automatic test_divisor();
        logic [7:0] exp_addr;
        cfg_write(2'd2, 24'd4);
        cfg_write(2'd0, 24'h400000);
        do_start(1'b0);
        exp_addr = 8'h00;
        n_cmp++;
        if (addr_valid !== 1'b1 || address !== exp_addr) begin
            n_err++;
            $display("FAIL div_first: got av=%b addr=%h want 1/00", addr_valid, address);
        end
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c % 4 == 0) exp_addr = 8'((c / 4) * 64);
            n_cmp++;
            if (addr_valid !== logic'(c % 4 == 0) || address !== exp_addr || wrap !== logic'(c == 16)) begin
                n_err++;
                $display("FAIL div_cycle%0d: got av=%b addr=%h wrap=%b want %b/%h/%b",
                         c, addr_valid, address, wrap, (c % 4 == 0), exp_addr, (c == 16));
            end
        end
        do_stop();
        $display("test_divisor complete");
    endtask

    task automatic test_offset();
        logic [7:0] exp_tbl [4];
        exp_tbl[0] = 8'hC0; exp_tbl[1] = 8'h00; exp_tbl[2] = 8'h40; exp_tbl[3] = 8'h80;
        cfg_write(2'd2, 24'd0);          // zero divisor must behave as 1
        cfg_write(2'd1, 24'h800000);
        cfg_write(2'd0, 24'h400000);
        do_start(1'b0);
        n_cmp++;
        if (addr_valid !== 1'b1 || address !== 8'h80 || wrap !== 1'b0) begin
            n_err++;
            $display("FAIL offset_first: got av=%b addr=%h wrap=%b want 1/80/0", addr_valid, address, wrap);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (addr_valid !== 1'b1 || address !== exp_tbl[i] || wrap !== logic'(i == 3)) begin
                n_err++;
                $display("FAIL offset_tick%0d: got av=%b addr=%h wrap=%b want 1/%h/%b",
                         i + 1, addr_valid, address, wrap, exp_tbl[i], (i == 3));
            end
        end
        do_stop();
        cfg_write(2'd1, 24'h000000);
        $display("test_offset complete");
    endtask

    task automatic test_burst();
        logic [7:0] exp_tbl [4];
        exp_tbl[0] = 8'h80; exp_tbl[1] = 8'h00; exp_tbl[2] = 8'h80; exp_tbl[3] = 8'h00;
        cfg_write(2'd3, 24'd2);
        cfg_write(2'd0, 24'h800000);
        do_start(1'b1);
        n_cmp++;
        if (addr_valid !== 1'b1 || address !== 8'h00 || done !== 1'b0) begin
            n_err++;
            $display("FAIL burst_first: got av=%b addr=%h done=%b want 1/00/0", addr_valid, address, done);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (addr_valid !== 1'b1 || address !== exp_tbl[i] || wrap !== logic'(i % 2 == 1)
                || done !== logic'(i == 3)) begin
                n_err++;
                $display("FAIL burst_tick%0d: got av=%b addr=%h wrap=%b done=%b want 1/%h/%b/%b",
                         i + 1, addr_valid, address, wrap, done, exp_tbl[i], (i % 2 == 1), (i == 3));
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL burst_busy_end: got %b want 0", busy);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (addr_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || address !== 8'h00) begin
                n_err++;
                $display("FAIL burst_after%0d: got av=%b done=%b busy=%b addr=%h want 0/0/0/00",
                         i, addr_valid, done, busy, address);
            end
        end
        $display("test_burst complete");
    endtask

    task automatic test_stop_reconfig();
        cfg_write(2'd0, 24'h010000);
        do_start(1'b0);
        for (int i = 0; i < 5; i++) step();
        n_cmp++;
        if (address !== 8'h05) begin
            n_err++;
            $display("FAIL reconf_pre: got addr=%h want 05", address);
        end
        cfg_valid = 1'b1; cfg_sel = 2'd2; cfg_data = 24'd7;
        #1;
        n_cmp++;
        if (cfg_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reconf_div_ready: got %b want 0", cfg_ready);
        end
        step();
        cfg_sel = 2'd0; cfg_data = 24'h020000;
        #1;
        n_cmp++;
        if (cfg_ready !== 1'b1 || address !== 8'h06) begin
            n_err++;
            $display("FAIL reconf_ftw_ready: got ready=%b addr=%h want 1/06", cfg_ready, address);
        end
        step();
        cfg_valid = 1'b0;
        n_cmp++;
        if (address !== 8'h07) begin
            n_err++;
            $display("FAIL reconf_old_step: got addr=%h want 07", address);
        end
        step();
        n_cmp++;
        if (address !== 8'h09 || addr_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reconf_new_step: got av=%b addr=%h want 1/09", addr_valid, address);
        end
        do_stop();
        n_cmp++;
        if (busy !== 1'b0 || addr_valid !== 1'b0 || done !== 1'b0 || address !== 8'h09) begin
            n_err++;
            $display("FAIL stop_edge: got busy=%b av=%b done=%b addr=%h want 0/0/0/09",
                     busy, addr_valid, done, address);
        end
        step(); step();
        n_cmp++;
        if (addr_valid !== 1'b0 || address !== 8'h09) begin
            n_err++;
            $display("FAIL stop_hold: got av=%b addr=%h want 0/09", addr_valid, address);
        end
        do_start(1'b0);
        step();
        n_cmp++;
        if (addr_valid !== 1'b1 || address !== 8'h02) begin
            n_err++;
            $display("FAIL reconf_div_kept: got av=%b addr=%h want 1/02", addr_valid, address);
        end
        do_stop();
        $display("test_stop_reconfig complete");
    endtask

    task automatic test_reset_midburst();
        cfg_write(2'd3, 24'd1);
        cfg_write(2'd0, 24'h800000);
        do_start(1'b1);
        step();
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({address, addr_valid, wrap, busy, done} !== 12'h000) begin
            n_err++;
            $display("FAIL midreset_outputs: got addr=%h av=%b wrap=%b busy=%b done=%b want all 0",
                     address, addr_valid, wrap, busy, done);
        end
        step();
        reset = 1'b0;
        cfg_write(2'd0, 24'h800000);
        do_start(1'b1);
        step();
        n_cmp++;
        if (address !== 8'h80 || wrap !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL restart_tick1: got addr=%h wrap=%b done=%b busy=%b want 80/0/0/1",
                     address, wrap, done, busy);
        end
        step();
        n_cmp++;
        if (address !== 8'h00 || wrap !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL restart_tick2: got addr=%h wrap=%b done=%b busy=%b want 00/1/1/0",
                     address, wrap, done, busy);
        end
        $display("test_reset_midburst complete");
    endtask

    task automatic test_burst_zero();
        cfg_write(2'd3, 24'd0);
        do_start(1'b1);
        n_cmp++;
        if (done !== 1'b1 || addr_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL burst0_start: got done=%b av=%b busy=%b want 1/0/0", done, addr_valid, busy);
        end
        step();
        n_cmp++;
        if (done !== 1'b0 || addr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL burst0_after: got done=%b av=%b want 0/0", done, addr_valid);
        end
        $display("test_burst_zero complete");
    endtask

    task automatic test_start_stop();
        start = 1'b1; stop = 1'b1; mode = 1'b0;
        step();
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (addr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                n_err++;
                $display("FAIL start_stop%0d: got av=%b busy=%b done=%b want 0/0/0", i, addr_valid, busy, done);
            end
            step();
        end
        $display("test_start_stop complete");
    endtask

    task automatic test_ftw_zero();
        cfg_write(2'd3, 24'd1);
        cfg_write(2'd0, 24'h000000);
        do_start(1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (addr_valid !== 1'b1 || address !== 8'h00 || wrap !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL ftw0_tick%0d: got av=%b addr=%h wrap=%b busy=%b done=%b want 1/00/0/1/0",
                         i + 1, addr_valid, address, wrap, busy, done);
            end
        end
        do_stop();
        $display("test_ftw_zero complete");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_divisor();
        test_offset();
        test_burst();
        test_stop_reconfig();
        test_reset_midburst();
        test_burst_zero();
        test_start_stop();
        test_ftw_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
